// File: rtl/spram_fifo_pkg.sv
// Shared constants and helpers for the single-port-RAM FIFO controller.
package spram_fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

    // Occupancy must cover RAM entries plus one in-flight read plus the output register.
    function automatic int cnt_width(input int addr_w);
        return $clog2((2 ** addr_w) + 2);
    endfunction

endpackage

// File: rtl/single_port_ram.sv
// 16x8 single-port RAM with a registered read port; contents are never reset.
module single_port_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];

    // Storage write and registered read through the shared address port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
        dout <= mem_r[addr];
    end

endmodule

// File: rtl/spram_fifo_ctrl.sv
// Synchronous FIFO controller sharing one RAM port between writes and reads.
// Optional direct input-to-output path when idle: define SPRAM_FIFO_BYPASS_EN.
module spram_fifo_ctrl
    import spram_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = cnt_width(ADDR_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(2 ** ADDR_W);

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   ram_cnt_r;
    logic              rd_pend_r;
    logic              m_valid_r;
    logic [DATA_W-1:0] m_data_r;

    logic              full_s;
    logic              slot_free_s;
    logic              do_rd_s;
    logic              do_wr_s;
    logic              do_byp_s;
    logic              hs_s;
    logic              s_ready_s;
    logic [CNT_W-1:0]  count_s;

    // Port arbitration: a read wins the single RAM port whenever one is due.
    always_comb begin
        full_s      = (ram_cnt_r == FULL_CNT);
        slot_free_s = !m_valid_r || m_ready;
        do_rd_s     = (ram_cnt_r != CNT_ZERO) && !rd_pend_r && slot_free_s;
        // rst_n gate keeps upstream stalled for the whole reset window.
        s_ready_s   = rst_n && !full_s && !do_rd_s;
        hs_s        = s_valid && s_ready_s;
`ifdef SPRAM_FIFO_BYPASS_EN
        do_byp_s    = hs_s && (ram_cnt_r == CNT_ZERO) && !rd_pend_r && slot_free_s;
`else
        do_byp_s    = 1'b0;
`endif
        do_wr_s     = hs_s && !do_byp_s;
        count_s     = CNT_W'(ram_cnt_r) + CNT_W'(rd_pend_r) + CNT_W'(m_valid_r);
    end

    // Pointer, RAM occupancy and in-flight read tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= {ADDR_W{1'b0}};
            rd_ptr_r  <= {ADDR_W{1'b0}};
            ram_cnt_r <= CNT_ZERO;
            rd_pend_r <= 1'b0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   ram_cnt_r <= ram_cnt_r + CNT_ONE;
                2'b01:   ram_cnt_r <= ram_cnt_r - CNT_ONE;
                default: ram_cnt_r <= ram_cnt_r;
            endcase
            rd_pend_r <= do_rd_s;
        end
    end

    // Output register: capture RAM data a cycle after the read, or bypassed input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r <= 1'b0;
            m_data_r  <= {DATA_W{1'b0}};
        end else if (rd_pend_r) begin
            m_valid_r <= 1'b1;
            m_data_r  <= ram_dout;
        end else if (do_byp_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= s_data;
        end else if (m_valid_r && m_ready) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

    assign s_ready  = s_ready_s;
    assign ram_we   = do_wr_s;
    assign ram_addr = do_rd_s ? rd_ptr_r : wr_ptr_r;
    assign ram_din  = s_data;
    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign count    = count_s;
    assign full     = full_s;
    assign empty    = (count_s == {CNT_W{1'b0}});

endmodule
